mil_line_arbiter: RTL and testbench



---
 rtl/mil_line_arbiter.sv | 130 +++++++++++++
 tb/tb_mil_line_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mil_line_arbiter.sv
// Arbitrates the shared 1553 line between the local transmitter and bus traffic:
// grants after a quiet gap, then times the remote response window.
module mil_line_arbiter #(
  parameter int unsigned IDLE_GAP     = 200,
  parameter int unsigned RESP_TIMEOUT = 700,
  parameter int unsigned TX_MAX       = 34000,
  parameter int unsigned BLANK        = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic lineP,
  input  logic lineN,
  input  logic txReq,
  input  logic txDone,
  output logic busy,
  output logic txGrant,
  output logic respStart,
  output logic noResp,
  output logic txTimeout
);

  localparam int unsigned QW   = $clog2(IDLE_GAP + 1);
  localparam int unsigned CMAX = (TX_MAX > RESP_TIMEOUT) ? TX_MAX : RESP_TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_LISTEN,
    S_BUSY,
    S_FREE,
    S_TX,
    S_WAIT_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    s0, s1, p;
  logic          act;
  logic [QW-1:0] quiet;
  logic [CW-1:0] cnt;
  logic          quiet_done, blanked, tx_expired, resp_expired;
  logic          busy_nxt, grant_nxt, resp_nxt, noresp_nxt, txto_nxt;
  logic          enter_idle, enter_timed;

  // Bit 0 carries lineP, bit 1 carries lineN.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s0 <= '0;
      s1 <= '0;
      p  <= '0;
    end else begin
      s0 <= {lineN, lineP};
      s1 <= s0;
      p  <= s1;
    end
  end

  assign act          = |(s1 ^ p);
  assign quiet_done   = !act && (quiet >= QW'(IDLE_GAP - 1));
  assign blanked      = cnt < CW'(BLANK);
  assign tx_expired   = cnt == CW'(TX_MAX - 1);
  assign resp_expired = cnt == CW'(RESP_TIMEOUT - 1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_LISTEN, S_BUSY: if (quiet_done) state_nxt = S_FREE;
      S_FREE: begin
        if (act)        state_nxt = S_BUSY;
        else if (txReq) state_nxt = S_TX;
      end
      S_TX: begin
        if (txDone)          state_nxt = S_WAIT_RESP;
        else if (tx_expired) state_nxt = S_LISTEN;
      end
      S_WAIT_RESP: begin
        if (act && !blanked) state_nxt = S_BUSY;
        else if (resp_expired) state_nxt = S_FREE;
      end
      default: state_nxt = S_LISTEN;
    endcase

    enter_idle  = (state_nxt != state) && (state_nxt == S_LISTEN || state_nxt == S_BUSY);
    enter_timed = (state_nxt != state) && (state_nxt == S_TX || state_nxt == S_WAIT_RESP);

    busy_nxt   = state_nxt != S_FREE;
    grant_nxt  = state_nxt == S_TX;
    resp_nxt   = (state == S_WAIT_RESP) && (state_nxt == S_BUSY);
    noresp_nxt = (state == S_WAIT_RESP) && (state_nxt == S_FREE);
    txto_nxt   = (state == S_TX) && (state_nxt == S_LISTEN);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_LISTEN;
      busy      <= 1'b1;
      txGrant   <= 1'b0;
      respStart <= 1'b0;
      noResp    <= 1'b0;
      txTimeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      txGrant   <= grant_nxt;
      respStart <= resp_nxt;
      noResp    <= noresp_nxt;
      txTimeout <= txto_nxt;
    end
  end

  // Clearing on LISTEN entry too forces a full quiet gap after a revoked grant.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      quiet <= '0;
    end else if (act || enter_idle) begin
      quiet <= '0;
    end else if (quiet != QW'(IDLE_GAP)) begin
      quiet <= quiet + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (enter_timed) begin
      cnt <= '0;
    end else if (state == S_TX || state == S_WAIT_RESP) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mil_line_arbiter.sv
// Directed bench for mil_line_arbiter with small timing parameters; outputs are
// compared as {busy, txGrant, respStart, noResp, txTimeout}.
module tb_mil_line_arbiter;

  logic clk = 1'b0;
  logic nRst, lineP, lineN, txReq, txDone;
  logic busy, txGrant, respStart, noResp, txTimeout;
  logic [4:0] outs;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       lp;
    logic       ln;
    logic       req;
    logic       done;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  assign outs = {busy, txGrant, respStart, noResp, txTimeout};

  mil_line_arbiter #(
    .IDLE_GAP    (8),
    .RESP_TIMEOUT(20),
    .TX_MAX      (50),
    .BLANK       (4)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .lineP    (lineP),
    .lineN    (lineN),
    .txReq    (txReq),
    .txDone   (txDone),
    .busy     (busy),
    .txGrant  (txGrant),
    .respStart(respStart),
    .noResp   (noResp),
    .txTimeout(txTimeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,grant,resp,noresp,txto) t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic lp, input logic ln, input logic req,
                     input logic done, input logic [4:0] exp);
    vec_t v;
    v.lp = lp; v.ln = ln; v.req = req; v.done = done; v.exp = exp;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    // Reset release with static lines, grant, txDone with an echo in blanking,
    // response at WAIT_RESP cycle 6, then a full quiet gap back to FREE.
    add(7, 0, 0, 0, 0, 5'b10000);
    add(1, 0, 0, 0, 0, 5'b00000);
    add(1, 0, 0, 1, 0, 5'b11000);
    add(9, 0, 0, 0, 0, 5'b11000);
    add(1, 0, 1, 0, 1, 5'b10000);
    add(3, 0, 1, 0, 0, 5'b10000);
    add(2, 0, 0, 0, 0, 5'b10000);
    add(1, 0, 0, 0, 0, 5'b10100);
    add(7, 0, 0, 0, 0, 5'b10000);
    add(1, 0, 0, 0, 0, 5'b00000);

    nRst = 1'b0; lineP = 1'b0; lineN = 1'b0; txReq = 1'b0; txDone = 1'b0;
    step();
    step();
    check("reset_values", outs, 5'b10000);
    nRst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      lineP = tbl[i].lp; lineN = tbl[i].ln; txReq = tbl[i].req; txDone = tbl[i].done;
      step();
      check($sformatf("vec%0d", i + 1), outs, tbl[i].exp);
    end

    // No response: noResp exactly 20 cycles after the txDone edge.
    txReq = 1'b1;
    step();
    check("t4_grant", outs, 5'b11000);
    txReq = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check("t4_tx_hold", outs, 5'b11000);
    end
    txDone = 1'b1;
    step();
    check("t4_done", outs, 5'b10000);
    txDone = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step();
      check("t4_wait", outs, 5'b10000);
    end
    step();
    check("t4_noresp", outs, 5'b00010);
    step();
    check("t4_free", outs, 5'b00000);

    // Bus traffic every 5 cycles keeps the line busy until 8 quiet cycles pass.
    for (int c = 0; c <= 45; c++) begin
      if (c % 5 == 0 && c <= 35) lineP = ~lineP;
      step();
      if (c < 2)       check("t2_pre_act", outs, 5'b00000);
      else if (c < 45) check("t2_busy", outs, 5'b10000);
      else             check("t2_free", outs, 5'b00000);
    end

    // act and txReq coincide in FREE: act wins.
    lineN = 1'b1;
    step();
    check("t6a_free0", outs, 5'b00000);
    step();
    check("t6a_free1", outs, 5'b00000);
    txReq = 1'b1;
    step();
    check("t6a_act_beats_req", outs, 5'b10000);
    txReq = 1'b0;
    lineN = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      step();
      check("t6a_busy", outs, 5'b10000);
    end
    step();
    check("t6a_free", outs, 5'b00000);

    // Grant held to TX_MAX, revoked, then re-grant only after a full quiet gap.
    txReq = 1'b1;
    step();
    check("t5_grant", outs, 5'b11000);
    for (int i = 1; i < 50; i++) begin
      step();
      check("t5_tx_hold", outs, 5'b11000);
    end
    step();
    check("t5_txtimeout", outs, 5'b10001);
    for (int i = 1; i < 8; i++) begin
      step();
      check("t5_gap", outs, 5'b10000);
    end
    step();
    check("t5_free", outs, 5'b00000);
    step();
    check("t5_regrant", outs, 5'b11000);
    txReq = 1'b0;
    txDone = 1'b1;
    step();
    check("t5_done", outs, 5'b10000);
    txDone = 1'b0;
    repeat (19) step();
    step();
    check("t5_noresp", outs, 5'b00010);

    // Asynchronous reset mid-TX.
    txReq = 1'b1;
    step();
    check("t6b_grant", outs, 5'b11000);
    txReq = 1'b0;
    repeat (3) step();
    #2 nRst = 1'b0;
    #1;
    check("t6b_async_reset", outs, 5'b10000);
    step();
    check("t6b_held_reset", outs, 5'b10000);
    nRst = 1'b1;
    repeat (7) step();
    check("t6b_listen", outs, 5'b10000);
    step();
    check("t6b_free", outs, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
